instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: stores a short program and plays it back.
// Build with SEQ_LOOP_EN defined to honour loop_mode.
module instr_sequencer #(
  parameter int INSTR_W     = 4,
  parameter int DEPTH       = 8,
  parameter int STEP_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic                       CLOCK50,
  input  logic                       rst_n,
  input  logic                       save,
  input  logic                       delete,
  input  logic                       execute,
  input  logic                       clear,
  input  logic                       pause,
  input  logic                       loop_mode,
  input  logic [INSTR_W-1:0]         instr_in,
  output logic [INSTR_W-1:0]         instr_out,
  output logic                       active,
  output logic [$clog2(DEPTH)-1:0]   step_idx,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       done,
  output logic                       err
);

  localparam int IW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int MAX1 = (STEP_CYCLES > GAP_CYCLES)
                      ? STEP_CYCLES : GAP_CYCLES;
  localparam int MAXC = (MAX1 > 2) ? MAX1 : 2;
  localparam int TW   = $clog2(MAXC);

  localparam logic [TW-1:0] S_LAST =
    TW'(STEP_CYCLES - 1);
  localparam logic [TW-1:0] G_LAST =
    TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP,
    PAUSE
  } state_t;

  state_t state_q, state_d;
  state_t ret_q, ret_d;

  logic [TW-1:0]      timer_q, timer_d;
  logic [IW-1:0]      step_d;
  logic [CW-1:0]      count_d;
  logic [INSTR_W-1:0] out_d;
  logic               act_d;
  logic               done_d;
  logic               err_d;
  logic               wr_en;
  logic               go_next;
  logic               ld;
  logic               last;
  logic               loop_en;

  logic [INSTR_W-1:0] mem [DEPTH];

`ifdef SEQ_LOOP_EN
  assign loop_en = loop_mode;
`else
  logic unused_loop;
  assign unused_loop = loop_mode;
  assign loop_en     = 1'b0;
`endif

  assign last = (CW'(step_idx) + CW'(1) == count);

  // Program storage; contents beyond count are unreachable.
  always_ff @(posedge CLOCK50) begin
    if (wr_en) begin
      mem[IW'(count)] <= instr_in;
    end
  end

  // Next-state, counters and registered outputs.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    timer_d = timer_q;
    step_d  = step_idx;
    count_d = count;
    out_d   = instr_out;
    act_d   = active;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    go_next = 1'b0;
    ld      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (execute) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            state_d = RUN;
            step_d  = '0;
            timer_d = '0;
            act_d   = 1'b1;
            ld      = 1'b1;
          end
        end else if (save && delete) begin
          err_d = 1'b1;
        end else if (save) begin
          if (full) begin
            err_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            count_d = count + CW'(1);
          end
        end else if (delete) begin
          if (empty) begin
            err_d = 1'b1;
          end else begin
            count_d = count - CW'(1);
          end
        end
      end
      RUN: begin
        if (pause) begin
          ret_d   = RUN;
          state_d = PAUSE;
          act_d   = 1'b0;
          out_d   = '0;
        end else if (timer_q != S_LAST) begin
          timer_d = timer_q + TW'(1);
        end else if (HAS_GAP) begin
          state_d = GAP;
          timer_d = '0;
          act_d   = 1'b0;
          out_d   = '0;
        end else begin
          go_next = 1'b1;
        end
      end
      GAP: begin
        if (pause) begin
          ret_d   = GAP;
          state_d = PAUSE;
        end else if (timer_q != G_LAST) begin
          timer_d = timer_q + TW'(1);
        end else begin
          go_next = 1'b1;
        end
      end
      PAUSE: begin
        if (pause) begin
          state_d = ret_q;
          if (ret_q == RUN) begin
            act_d = 1'b1;
            ld    = 1'b1;
          end
        end
      end
    endcase

    if (go_next) begin
      timer_d = '0;
      if (last && !loop_en) begin
        state_d = IDLE;
        step_d  = '0;
        act_d   = 1'b0;
        out_d   = '0;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
        step_d  = last ? '0 : step_idx + IW'(1);
        act_d   = 1'b1;
        ld      = 1'b1;
      end
    end

    if (ld) begin
      out_d = mem[step_d];
    end

    if (clear) begin
      state_d = IDLE;
      ret_d   = IDLE;
      timer_d = '0;
      step_d  = '0;
      count_d = '0;
      out_d   = '0;
      act_d   = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge CLOCK50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ret_q     <= IDLE;
      timer_q   <= '0;
      step_idx  <= '0;
      count     <= '0;
      instr_out <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      timer_q   <= timer_d;
      step_idx  <= step_d;
      count     <= count_d;
      instr_out <= out_d;
      active    <= act_d;
      done      <= done_d;
      err       <= err_d;
      full      <= (count_d == CW'(DEPTH));
      empty     <= (count_d == '0);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus random
// stimulus against a phase-list playback model.
module tb_instr_sequencer;

  localparam int D = 4;
  localparam int S = 4;
  localparam int G = 2;

  logic       CLOCK50 = 1'b0;
  logic       rst_n   = 1'b1;
  logic       save    = 1'b0;
  logic       delete  = 1'b0;
  logic       execute = 1'b0;
  logic       clear   = 1'b0;
  logic       pause   = 1'b0;
  logic       loop_mode = 1'b0;
  logic [3:0] instr_in  = 4'h0;
  logic [3:0] instr_out;
  logic       active;
  logic [1:0] step_idx;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       done;
  logic       err;

  always #5 CLOCK50 = ~CLOCK50;

  instr_sequencer #(
    .INSTR_W(4),
    .DEPTH(D),
    .STEP_CYCLES(S),
    .GAP_CYCLES(G)
  ) dut (
    .CLOCK50(CLOCK50),
    .rst_n(rst_n),
    .save(save),
    .delete(delete),
    .execute(execute),
    .clear(clear),
    .pause(pause),
    .loop_mode(loop_mode),
    .instr_in(instr_in),
    .instr_out(instr_out),
    .active(active),
    .step_idx(step_idx),
    .count(count),
    .full(full),
    .empty(empty),
    .done(done),
    .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int v;
    bit a;
    int s;
    int len;
  } ph_t;

  ph_t ph_q[$];
  int  m_rem;
  int  m_mode;
  int  m_cnt;
  int  m_mem[D];
  bit  m_done;
  bit  m_err;
`ifdef SEQ_LOOP_EN
  bit  m_loop_ok = 1'b1;
`else
  bit  m_loop_ok = 1'b0;
`endif

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void build();
    ph_t p;
    ph_q.delete();
    for (int i = 0; i < m_cnt; i++) begin
      p.v = m_mem[i]; p.a = 1'b1;
      p.s = i; p.len = S;
      ph_q.push_back(p);
      if (G > 0) begin
        p.v = 0; p.a = 1'b0;
        p.s = i; p.len = G;
        ph_q.push_back(p);
      end
    end
    m_rem = ph_q[0].len;
  endfunction

  function automatic void model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    ph_q.delete();
  endfunction

  function automatic void model_step();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (clear) begin
      m_mode = 0;
      m_cnt  = 0;
      ph_q.delete();
    end else if (m_mode == 0) begin
      if (execute) begin
        if (m_cnt > 0) begin
          build();
          m_mode = 1;
        end else begin
          m_err = 1'b1;
        end
      end else if (save && delete) begin
        m_err = 1'b1;
      end else if (save) begin
        if (m_cnt < D) begin
          m_mem[m_cnt] = int'(instr_in);
          m_cnt++;
        end else begin
          m_err = 1'b1;
        end
      end else if (delete) begin
        if (m_cnt > 0) m_cnt--;
        else m_err = 1'b1;
      end
    end else if (m_mode == 1) begin
      if (pause) begin
        m_mode = 2;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          void'(ph_q.pop_front());
          if (ph_q.size() > 0) begin
            m_rem = ph_q[0].len;
          end else if (m_loop_ok && loop_mode) begin
            build();
          end else begin
            m_mode = 0;
            m_done = 1'b1;
          end
        end
      end
    end else begin
      if (pause) m_mode = 1;
    end
  endfunction

  task automatic compare_all();
    int e_out;
    int e_act;
    int e_step;
    e_out  = 0;
    e_act  = 0;
    e_step = 0;
    if (m_mode != 0) begin
      e_step = ph_q[0].s;
      if (m_mode == 1 && ph_q[0].a) begin
        e_act = 1;
        e_out = ph_q[0].v;
      end
    end
    chk("instr_out", 32'(instr_out), 32'(e_out));
    chk("active", 32'(active), 32'(e_act));
    chk("step_idx", 32'(step_idx), 32'(e_step));
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == D));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("done", 32'(done), 32'(m_done));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic cycle();
    @(posedge CLOCK50);
    if (!rst_n) model_reset();
    else model_step();
    cyc++;
    #1;
    compare_all();
  endtask

  task automatic pulses_off();
    save    = 1'b0;
    delete  = 1'b0;
    execute = 1'b0;
    clear   = 1'b0;
    pause   = 1'b0;
  endtask

  task automatic do_save(input logic [3:0] v);
    save = 1'b1; instr_in = v;
    cycle();
    save = 1'b0;
  endtask

  task automatic do_del();
    delete = 1'b1;
    cycle();
    delete = 1'b0;
  endtask

  task automatic do_exec();
    execute = 1'b1;
    cycle();
    execute = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  task automatic do_pause();
    pause = 1'b1;
    cycle();
    pause = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int k;
    k = 0;
    while (done !== 1'b1 && k < max) begin
      cycle();
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int t0;
    int r;
    bit seen_done;

    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge CLOCK50);
    rst_n = 1'b1;

    do_save(4'h5);
    do_save(4'hA);
    do_save(4'h3);
    t0 = cyc;
    do_exec();
    wait_done(100);
    chk("len_plain", 32'(cyc - t0), 32'd19);
    chk("cnt_after", 32'(count), 32'd3);

    t0 = cyc;
    do_exec();
    repeat (8) cycle();
    do_pause();
    repeat (10) cycle();
    chk("pause_step", 32'(step_idx), 32'd1);
    chk("pause_act", 32'(active), 32'd0);
    do_pause();
    chk("resume_act", 32'(active), 32'd1);
    chk("resume_val", 32'(instr_out), 32'hA);
    wait_done(100);
    chk("len_pause", 32'(cyc - t0), 32'd31);

    do_clear();
    for (int i = 0; i < 5; i++) begin
      do_save(4'(i + 1));
      if (i == 3) chk("full4", 32'(full), 32'd1);
    end
    chk("err_full", 32'(err), 32'd1);
    chk("cnt_full", 32'(count), 32'd4);
    do_del();
    chk("cnt_del", 32'(count), 32'd3);
    chk("full_del", 32'(full), 32'd0);

    do_clear();
    do_exec();
    chk("err_exec0", 32'(err), 32'd1);
    chk("act_exec0", 32'(active), 32'd0);
    do_del();
    chk("err_del0", 32'(err), 32'd1);

    do_save(4'h7);
    do_save(4'h9);
    loop_mode = 1'b1;
    do_exec();
    seen_done = 1'b0;
    repeat (30) begin
      cycle();
      if (done === 1'b1) seen_done = 1'b1;
    end
`ifdef SEQ_LOOP_EN
    chk("loop_nodone", 32'(seen_done), 32'd0);
    while (active !== 1'b1) cycle();
    do_clear();
    chk("clr_cnt", 32'(count), 32'd0);
    chk("clr_act", 32'(active), 32'd0);
`else
    chk("noloop_done", 32'(seen_done), 32'd1);
`endif
    loop_mode = 1'b0;
    do_clear();

    for (int i = 0; i < 3000; i++) begin
      pulses_off();
      r = $urandom_range(0, 99);
      instr_in = 4'($urandom);
      if (r < 22) save = 1'b1;
      else if (r < 32) delete = 1'b1;
      else if (r < 35) begin
        save = 1'b1;
        delete = 1'b1;
      end
      else if (r < 43) execute = 1'b1;
      else if (r < 45) clear = 1'b1;
      else if (r < 50) pause = 1'b1;
      if ($urandom_range(0, 63) == 0)
        loop_mode = ~loop_mode;
      cycle();
    end
    pulses_off();
    loop_mode = 1'b0;

    do_clear();
    do_save(4'hC);
    do_save(4'h6);
    do_exec();
    repeat (2) cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_act", 32'(active), 32'd0);
    chk("rst_out", 32'(instr_out), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    model_reset();
    compare_all();
    cycle();
    rst_n = 1'b1;
    do_exec();
    chk("rst_exec_err", 32'(err), 32'd1);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
